// File: rtl/tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tx_pkt_arbiter
//   Arbitrates two packet sources (0 = telemetry, 1 = fault/alert) onto one
//   shared UART transmitter. A granted source's 48-bit payload is latched and
//   sent as a 10-byte frame:
//     AA 55 ID P[47:40] .. P[7:0] CKSUM
//   CKSUM makes bytes 2..9 sum to zero mod 256. Ties between the two sources
//   are broken round-robin. A per-byte tx_done timeout aborts the frame.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req0/1     packet request from source 0/1
//   payload0/1 48-bit payload, captured on the grant edge
//   ack0/1     one-cycle grant pulse
//   trmt       one-cycle start strobe to the UART
//   tx_data    byte to the UART, valid with trmt and held until the next byte
//   tx_done    UART byte-complete level
//   busy       high while a frame is in progress
//   err        one-cycle pulse when a frame is aborted on timeout
// -----------------------------------------------------------------------------
module tx_pkt_arbiter #(
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [47:0] payload0,
  output logic        ack0,
  input  logic        req1,
  input  logic [47:0] payload1,
  output logic        ack1,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TMO_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t             state_r;
  logic [3:0]         idx_r;
  logic               src_r;      // source of the frame in flight
  logic               last_r;     // last source served
  logic [47:0]        payload_r;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic               ack0_r;
  logic               ack1_r;
  logic               trmt_r;
  logic [7:0]         tx_data_r;
  logic               busy_r;
  logic               err_r;

  logic               grant_v_s;
  logic               grant_src_s;

  // Two's-complement checksum over the ID and six payload bytes.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] id,
                                              input logic [47:0] pl);
    logic [7:0] sum;
    sum = id + pl[47:40] + pl[39:32] + pl[31:24] + pl[23:16] + pl[15:8] + pl[7:0];
    return 8'h00 - sum;
  endfunction

  // Byte at frame position idx for the given source and latched payload.
  function automatic logic [7:0] pkt_byte(input logic [3:0] idx,
                                          input logic src,
                                          input logic [47:0] pl);
    logic [7:0] id;
    logic [7:0] b;
    id = src ? 8'h02 : 8'h01;
    case (idx)
      4'd0:    b = 8'hAA;
      4'd1:    b = 8'h55;
      4'd2:    b = id;
      4'd3:    b = pl[47:40];
      4'd4:    b = pl[39:32];
      4'd5:    b = pl[31:24];
      4'd6:    b = pl[23:16];
      4'd7:    b = pl[15:8];
      4'd8:    b = pl[7:0];
      4'd9:    b = pkt_checksum(id, pl);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Round-robin pick: on a tie the source not served last wins.
  always_comb begin
    grant_v_s   = 1'b0;
    grant_src_s = 1'b0;
    if (req0 && req1) begin
      grant_v_s   = 1'b1;
      grant_src_s = ~last_r;
    end else if (req0) begin
      grant_v_s   = 1'b1;
      grant_src_s = 1'b0;
    end else if (req1) begin
      grant_v_s   = 1'b1;
      grant_src_s = 1'b1;
    end else begin
      grant_v_s   = 1'b0;
      grant_src_s = 1'b0;
    end
  end

  // Frame sequencer with registered strobes and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 4'd0;
      src_r     <= 1'b0;
      last_r    <= 1'b1;
      payload_r <= 48'h0;
      tmo_cnt_r <= '0;
      ack0_r    <= 1'b0;
      ack1_r    <= 1'b0;
      trmt_r    <= 1'b0;
      tx_data_r <= 8'h00;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      trmt_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_v_s) begin
            src_r     <= grant_src_s;
            last_r    <= grant_src_s;
            payload_r <= grant_src_s ? payload1 : payload0;
            ack0_r    <= ~grant_src_s;
            ack1_r    <= grant_src_s;
            idx_r     <= 4'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_data_r <= pkt_byte(idx_r, src_r, payload_r);
          trmt_r    <= 1'b1;
          tmo_cnt_r <= '0;
          state_r   <= ST_GUARD;
        end
        // One cycle in which a stale tx_done from the previous byte is ignored.
        ST_GUARD: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (idx_r == 4'd9) begin
              idx_r   <= 4'd0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              idx_r   <= idx_r + 4'd1;
              state_r <= ST_LOAD;
            end
          end else if (tmo_cnt_r >= TMO_MAX - CNT_W'(1)) begin
            // This is the TMO_CYC-th WAIT cycle without tx_done: abort.
            tmo_cnt_r <= TMO_MAX;
            err_r     <= 1'b1;
            idx_r     <= 4'd0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0    = ack0_r;
  assign ack1    = ack1_r;
  assign trmt    = trmt_r;
  assign tx_data = tx_data_r;
  assign busy    = busy_r;
  assign err     = err_r;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_pkt_arbiter
//   Randomized self-checking bench for tx_pkt_arbiter. A UART model answers
//   each trmt with tx_done after a programmable delay, clearing its done level
//   one cycle late so the guard cycle sees a stale tx_done. Expected frames are
//   built from the payload and a round-robin winner predicted by the bench.
// -----------------------------------------------------------------------------
module tb_tx_pkt_arbiter;

  localparam int unsigned TMO = 250;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [47:0] payload0;
  logic        ack0;
  logic        req1;
  logic [47:0] payload1;
  logic        ack1;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        err;

  int vec_cnt = 0;
  int mis_cnt = 0;

  // Bench-side state
  bit         last_src;
  int         dly_min;
  int         dly_max;
  int         stuck_at;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         trmt_cnt = 0;
  int         last_trmt_cyc = 0;
  int         err_pulses = 0;
  int         err_cyc = 0;
  logic       err_busy = 1'b0;
  bit         arm = 1'b0;
  int         cd = 0;

  tx_pkt_arbiter #(.TMO_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .payload0 (payload0),
    .ack0     (ack0),
    .req1     (req1),
    .payload1 (payload1),
    .ack1     (ack1),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  // Expected frame: header, ID, payload MSB first, negated sum of bytes 2..8.
  task automatic build_exp(input bit src, input logic [47:0] pl);
    int s;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(src ? 8'h02 : 8'h01);
    for (int i = 5; i >= 0; i--) exp_q.push_back(pl[i*8 +: 8]);
    s = 0;
    for (int i = 2; i < 9; i++) s += int'(exp_q[i]);
    exp_q.push_back(8'((256 - (s % 256)) % 256));
  endtask

  // UART model and output monitor, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      tx_done = 1'b1;
      arm     = 1'b0;
      cd      = 0;
    end else begin
      if (arm) begin
        arm     = 1'b0;
        tx_done = 1'b0;
        if (stuck_at >= 0 && (cap_q.size() - 1) >= stuck_at) cd = -1;
        else cd = $urandom_range(dly_max, dly_min);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
      if (trmt) begin
        cap_q.push_back(tx_data);
        trmt_cnt++;
        last_trmt_cyc = cyc;
        arm = 1'b1;
      end
      if (ack0 || ack1) chk_eq("ack_exclusive", 64'(ack0 & ack1), 64'(0));
      if (err) begin
        err_pulses++;
        err_cyc  = cyc;
        err_busy = busy;
      end
    end
  end

  task automatic wait_ack(output int n);
    n = 0;
    while (!(ack0 || ack1) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("busy_end", 64'(busy), 64'(0));
  endtask

  // Called at a negedge; ends at the negedge where busy is first seen low.
  task automatic do_packet(input bit w0, input bit w1, input logic [47:0] p0,
                           input logic [47:0] p1, input bit lat, input int nexp);
    int n;
    bit win;
    logic [7:0] got;
    if (w0) begin req0 = 1'b1; payload0 = p0; end
    if (w1) begin req1 = 1'b1; payload1 = p1; end
    if (req0 && req1) win = ~last_src;
    else win = req1 && !req0;
    build_exp(win, win ? payload1 : payload0);
    cap_q.delete();
    wait_ack(n);
    if (lat) chk_eq("ack_latency", 64'(n), 64'(1));
    chk_eq("ack_src", 64'({ack1, ack0}), win ? 64'(2) : 64'(1));
    last_src = win;
    // Winner lets go and scribbles its payload; frame must not change.
    if (win) begin req1 = 1'b0; payload1 = rand48(); end
    else begin req0 = 1'b0; payload0 = rand48(); end
    if (lat) begin
      @(negedge clk);
      chk_eq("trmt_latency", 64'(trmt), 64'(1));
    end
    wait_idle();
    chk_eq("n_bytes", 64'(cap_q.size()), 64'(nexp));
    for (int i = 0; i < nexp; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      chk_eq($sformatf("byte%0d", i), 64'(got), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] got;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    payload0 = 48'h0; payload1 = 48'h0;
    last_src = 1'b1; stuck_at = -1; dly_min = 1; dly_max = 6;
    repeat (3) @(negedge clk);
    chk_eq("rst_outputs", 64'({ack0, ack1, trmt, busy, err}), 64'(0));
    chk_eq("rst_tx_data", 64'(tx_data), 64'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("no_trmt_idle", 64'(trmt_cnt), 64'(0));
    chk_eq("idle_busy", 64'(busy), 64'(0));

    // Slow UART, known payload and checksum.
    dly_min = 200; dly_max = 200;
    do_packet(1'b1, 1'b0, 48'h0123456789AB, 48'h0, 1'b1, 10);
    got = (cap_q.size() >= 10) ? cap_q[9] : 8'hxx;
    chk_eq("cksum_known", 64'(got), 64'(8'hFB));

    // Simultaneous requests alternate round-robin, one idle cycle apart.
    dly_min = 1; dly_max = 5;
    do_packet(1'b1, 1'b1, rand48(), rand48(), 1'b1, 10);
    do_packet(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 10);
    do_packet(1'b1, 1'b1, rand48(), rand48(), 1'b1, 10);
    do_packet(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 10);

    // tx_done stuck low after byte 3: abort while waiting on byte 4.
    stuck_at = 4;
    err_pulses = 0;
    do_packet(1'b1, 1'b0, rand48(), 48'h0, 1'b1, 5);
    repeat (5) @(negedge clk);
    chk_eq("err_pulses", 64'(err_pulses), 64'(1));
    chk_eq("err_timing", 64'(err_cyc - last_trmt_cyc), 64'(TMO + 1));
    chk_eq("err_busy", 64'(err_busy), 64'(0));
    stuck_at = -1;
    do_packet(1'b0, 1'b1, 48'h0, rand48(), 1'b1, 10);

    // Asynchronous reset in the middle of byte 5.
    req0 = 1'b1; payload0 = rand48();
    cap_q.delete();
    wait_ack(n);
    chk_eq("rst_pre_ack", 64'(ack0), 64'(1));
    req0 = 1'b0;
    n = 0;
    while (cap_q.size() < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("rst_reached_b5", 64'(cap_q.size()), 64'(6));
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_async_ctl", 64'({ack0, ack1, trmt, busy, err}), 64'(0));
    chk_eq("rst_async_data", 64'(tx_data), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_src = 1'b1;
    n = trmt_cnt;
    repeat (4) @(negedge clk);
    chk_eq("post_rst_no_trmt", 64'(trmt_cnt - n), 64'(0));
    do_packet(1'b0, 1'b1, 48'h0, rand48(), 1'b1, 10);

    // Randomized traffic.
    err_pulses = 0;
    for (int it = 0; it < 12; it++) begin
      int pat;
      pat = $urandom_range(2, 0);
      dly_min = 1;
      dly_max = $urandom_range(12, 1);
      do_packet(pat != 1, pat != 0, rand48(), rand48(), 1'b1, 10);
    end
    for (int k = 0; k < 2; k++) begin
      if (req0 || req1) do_packet(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 10);
    end
    chk_eq("no_spurious_err", 64'(err_pulses), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
